serial_compare: RTL
===================

SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit nibbles per operand; legal range 1..8.
REQ-002 Port: clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port: rst_n, input, 1, reset, synchronous, active-low.
REQ-004 Port: start, input, 1, request to begin a comparison; sampled only in IDLE.
REQ-005 Port: x, input, 4*NIBBLES, operand A, unsigned, captured when start is accepted.
REQ-006 Port: y, input, 4*NIBBLES, operand B, unsigned, captured when start is accepted.
REQ-007 Port: busy, output, 1, high while state is RUN or DONE.
REQ-008 Port: done, output, 1, one-cycle pulse marking valid eq/gt/lt.
REQ-009 Port: eq, output, 1, registered result x==y.
REQ-010 Port: gt, output, 1, registered result x>y.
REQ-011 Port: lt, output, 1, registered result x<y.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL latch x and y into shift registers, load nibble counter with NIBBLES-1, clear eq/gt/lt, and go to RUN.
REQ-014 IDLE with start=0 SHALL hold all state.
REQ-015 RUN SHALL compare the current most-significant unprocessed nibble pair once per cycle, MSB nibble first.
REQ-016 RUN with nibbles unequal SHALL set gt (A nibble > B nibble) or lt (otherwise), keep eq=0, and go to DONE (early exit).
REQ-017 RUN with nibbles equal and counter nonzero SHALL shift both registers left by 4 bits, decrement the counter, and stay in RUN.
REQ-018 RUN with nibbles equal and counter zero SHALL set eq=1 and go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-020 Latency: done SHALL be high during the cycle after edge k+m, where k is the accepting edge and m = 1-based index of the first mismatching nibble (MSB=1), or m=NIBBLES if all nibbles are equal.
REQ-021 Exactly one of eq/gt/lt SHALL be high while done is high.
REQ-022 eq/gt/lt SHALL hold their values after done until the next accepted start clears them.
REQ-023 start SHALL be ignored in RUN and DONE; operand changes during RUN SHALL not affect the result.
REQ-024 start high during the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-025 busy SHALL equal (state != IDLE), combinationally from state.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state IDLE and done, eq, gt, lt, busy, the shift registers and the counter to 0, overriding any other event in that cycle.
REQ-027 Reset asserted mid-RUN SHALL abandon the comparison with no done pulse.

Structure
REQ-028 The shared ALU package SHALL hold NIBBLE_W=4 and the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
REQ-029 Nibble equality SHALL be computed by one instance of the existing 4-bit equality comparator module (equal); only the magnitude decision (gt/lt) is local logic.
REQ-030 The counter SHALL be $clog2(NIBBLES)+1 bits wide, minimum 1.

Verification (NIBBLES=4)
REQ-031 x=16'h1234, y=16'h1234, start at edge k -> done high after edge k+4, eq=1, gt=0, lt=0.
REQ-032 x=16'h8000, y=16'h7FFF -> done high after edge k+1, gt=1, eq=0, lt=0.
REQ-033 x=16'h12A4, y=16'h12B4 -> done high after edge k+3, lt=1; results still held 5 cycles later with start=0.
REQ-034 start with x=16'h0001, y=16'h0000, then at edge k+1 drive start=1, x=16'hFFFF -> second start ignored; done after edge k+4 with gt=1.
REQ-035 rst_n=0 at edge k+2 of an equal-operand run -> all outputs 0 after that edge, no done pulse; a new start after release completes normally.
REQ-036 start held high continuously with x=y=16'h0000 -> done pulses every 6 cycles (accept, 4 RUN, DONE, IDLE re-accept), eq=1 each time.

Source files
------------

// File: rtl/serial_compare_pkg.sv
// Shared ALU package for the serial magnitude comparator.
// Holds the nibble width and the FSM state encodings used by the
// comparator top and its nibble-equality sub-module.
package serial_compare_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_compare_pkg

// File: rtl/serial_compare_equal.sv
// equal: 4-bit equality comparator.
// Ports:
//   i_a, i_b : nibbles to compare
//   o_eq     : 1 when i_a == i_b (combinational)
module equal
  import serial_compare_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  output logic                o_eq
);

  assign o_eq = (i_a == i_b);

endmodule : equal

// File: rtl/serial_compare.sv
// serial_compare: compares two unsigned operands one nibble per cycle,
// most-significant nibble first, exiting as soon as a nibble differs.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin a comparison (only honoured in IDLE)
//   x, y       : operands A and B, captured when start is accepted
//   busy       : high while a comparison is in RUN or DONE
//   done       : one-cycle pulse, eq/gt/lt are valid
//   eq, gt, lt : registered result, held until the next accepted start
module serial_compare
  import serial_compare_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*NIBBLES-1:0]      x,
  input  logic [4*NIBBLES-1:0]      y,
  output logic                      busy,
  output logic                      done,
  output logic                      eq,
  output logic                      gt,
  output logic                      lt
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               r_eq;
  logic               r_gt;
  logic               r_lt;

  logic [NIBBLE_W-1:0] w_nib_a;
  logic [NIBBLE_W-1:0] w_nib_b;
  logic                w_nib_eq;

  // The unprocessed nibble pair always sits at the top of the shift registers.
  assign w_nib_a = r_a[W-1 -: NIBBLE_W];
  assign w_nib_b = r_b[W-1 -: NIBBLE_W];

  equal u_equal (
    .i_a  (w_nib_a),
    .i_b  (w_nib_b),
    .o_eq (w_nib_eq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      // done is raised only on the transition into DONE, so it lasts one cycle.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= x;
            r_b     <= y;
            r_cnt   <= CNT_LOAD;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!w_nib_eq) begin
            // First differing nibble decides the magnitude; no need to look further.
            r_gt    <= (w_nib_a > w_nib_b);
            r_lt    <= !(w_nib_a > w_nib_b);
            r_eq    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt != '0) begin
            r_a     <= r_a << NIBBLE_W;
            r_b     <= r_b << NIBBLE_W;
            r_cnt   <= r_cnt - CNT_ONE;
          end else begin
            r_eq    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule : serial_compare
